// File: rtl/imem_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_fetch                                                    |
// | Function : Writable instruction memory with a valid/ready fetch port.    |
// |            Reads happen at the accept edge. Results pass through         |
// |            RD_LAT-1 register stages into an in-order response queue.     |
// |            A flush discards everything in flight. A load port writes     |
// |            program words. Fetch indices are range checked.               |
// | Option   : `define IMEM_MISALIGN_EN makes a non-word-aligned req_addr    |
// |            return a fault instead of the containing word.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module imem_fetch #(
  parameter int N      = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [N-1:0]             rsp_data,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [N-1:0]             load_data,
  output logic                     busy
);

  // Word-index width, queue depth, and the widths of the counters and pointers.
  localparam int C_AW = $clog2(DEPTH);
  localparam int C_QD = RD_LAT + 1;
  localparam int C_CW = $clog2(C_QD + 1);
  localparam int C_PW = $clog2(C_QD);
  localparam int C_QS = 1 << C_PW;
  localparam logic [C_CW-1:0] C_CNT_MAX  = C_CW'(C_QD);
  localparam logic [C_PW-1:0] C_PTR_LAST = C_PW'(C_QD - 1);

  // Program storage. It is not reset, so contents survive rst_n.
  logic [N-1:0]      r_mem [DEPTH];

  // Count of accepted fetches not yet popped, covering the pipeline and the queue.
  logic [C_CW-1:0]   r_cnt;

  // Response queue.
  logic [N-1:0]      r_q_data [C_QS];
  logic              r_q_err  [C_QS];
  logic [C_PW-1:0]   r_wptr;
  logic [C_PW-1:0]   r_rptr;
  logic [C_CW-1:0]   r_qcnt;

  logic              w_accept;
  logic              w_pop;
  logic              w_oor;
  logic              w_mis;
  logic              w_err;
  logic [C_AW-1:0]   w_idx;
  logic [N-1:0]      w_rd_data;
  logic              w_push;
  logic              w_push_err;
  logic [N-1:0]      w_push_data;

  // Advance a queue pointer. The queue depth need not be a power of two.
  function automatic logic [C_PW-1:0] f_next(input logic [C_PW-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode. Readiness depends on the registered count only.
  assign req_ready = rst_n & (r_cnt < C_CNT_MAX) & ~load_en & ~flush;
  assign w_accept  = req_valid & req_ready;
  assign rsp_valid = (r_qcnt != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign busy      = (r_cnt != '0);

  // Word index into the array. Any byte-address bits above the array range are a fault.
  assign w_idx = req_addr[C_AW+1:2];

  generate
    if (ADDR_W > C_AW + 2) begin : g_hi_chk
      assign w_oor = |req_addr[ADDR_W-1:C_AW+2];
    end else begin : g_no_hi
      assign w_oor = 1'b0;
    end
  endgenerate

`ifdef IMEM_MISALIGN_EN
  assign w_mis = |req_addr[1:0];
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^req_addr[1:0];
  assign w_mis        = 1'b0;
`endif

  // A faulting fetch returns zero data.
  assign w_err     = w_oor | w_mis;
  assign w_rd_data = w_err ? '0 : r_mem[w_idx];

  // Delay the read result so it reaches the queue RD_LAT-1 edges after the accept edge.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_push      = w_accept;
      assign w_push_data = w_rd_data;
      assign w_push_err  = w_err;
    end else begin : g_lat2
      logic         r_p_valid;
      logic [N-1:0] r_p_data;
      logic         r_p_err;

      // Single read-data stage. A flush drops whatever it holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p_valid <= 1'b0;
          r_p_data  <= '0;
          r_p_err   <= 1'b0;
        end else begin
          r_p_valid <= w_accept & ~flush;
          r_p_data  <= w_rd_data;
          r_p_err   <= w_err;
        end
      end

      assign w_push      = r_p_valid;
      assign w_push_data = r_p_data;
      assign w_push_err  = r_p_err;
    end
  endgenerate

  // Program load. No fetch is accepted in a load cycle, so reads see settled data.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Outstanding-fetch count. Accept and pop together cancel; flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Queue control: pointers and fill level. Flush takes priority over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_qcnt <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_qcnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= f_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_qcnt <= r_qcnt + 1'b1;
        2'b01:   r_qcnt <= r_qcnt - 1'b1;
        default: r_qcnt <= r_qcnt;
      endcase
    end
  end

  // Queue storage. The output is gated while empty, so this needs no reset.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_q_data[r_wptr] <= w_push_data;
      r_q_err[r_wptr]  <= w_push_err;
    end
  end

  // The head entry is presented only while valid, and holds until it is popped.
  assign rsp_data = rsp_valid ? r_q_data[r_rptr] : '0;
  assign rsp_err  = rsp_valid & r_q_err[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_fetch                                                 |
// | Function : Drives identical stimulus into imem_fetch instances with      |
// |            RD_LAT=1 and RD_LAT=2. Each instance is compared every cycle  |
// |            against an in-order transaction model of the fetch port.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_imem_fetch;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        flush;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;

  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic [1:0]  er;
  logic [1:0]  bsy;
  logic [31:0] dat0;
  logic [31:0] dat1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  string phase = "init";

  // Reference state: memory image, plus one in-order list of outstanding fetches per instance.
  logic [31:0] mm [DEPTH];
  logic [31:0] qd [2][4];
  logic        qe [2][4];
  int          qv [2][4];
  int          qh [2];
  int          qn [2];

  always #5 clk = ~clk;

  imem_fetch #(.N(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_addr(req_addr), .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
    .rsp_data(dat0), .rsp_err(er[0]), .flush(flush), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(bsy[0]));

  imem_fetch #(.N(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_addr(req_addr), .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
    .rsp_data(dat1), .rsp_err(er[1]), .flush(flush), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(bsy[1]));

  function automatic int lat(input int i);
    return i + 1;
  endfunction

  function automatic logic [31:0] dsel(input int i);
    return (i == 0) ? dat0 : dat1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s cyc=%0d observed=%h expected=%h", phase, tag, cyc, obs, exp);
    end
  endtask

  // Expected response for a byte address, taken from the memory image.
  task automatic exp_rsp(input logic [31:0] a, output logic [31:0] d, output logic e);
    logic mis;
    mis = 1'b0;
`ifdef IMEM_MISALIGN_EN
    mis = (a[1:0] != 2'b00);
`endif
    e = (a >= 32'(4 * DEPTH)) || mis;
    d = e ? 32'h0 : mm[a[7:2]];
  endtask

  task automatic chk_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'h0);
      chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'h0);
      chk($sformatf("rst_data%0d", i), dsel(i), 32'h0);
      chk($sformatf("rst_err%0d", i), 32'(er[i]), 32'h0);
      chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'h0);
    end
  endtask

  // One clock: check outputs against the model, take the edge, then update the model.
  task automatic tick();
    logic        acc [2];
    logic        pop [2];
    logic        ev;
    logic        exr;
    logic [31:0] ed;
    logic        ee;
    int          slot;
    #1;
    for (int i = 0; i < 2; i++) begin
      exr = (qn[i] < lat(i) + 1) && !load_en && !flush;
      ev  = (qn[i] > 0) && (qv[i][qh[i]] <= cyc);
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exr));
      chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(ev));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(qn[i] != 0));
      if (ev) begin
        chk($sformatf("data%0d", i), dsel(i), qd[i][qh[i]]);
        chk($sformatf("err%0d", i), 32'(er[i]), 32'(qe[i][qh[i]]));
      end
      acc[i] = req_valid && exr;
      pop[i] = ev && rsp_ready;
    end
    exp_rsp(req_addr, ed, ee);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (flush) begin
        qn[i] = 0;
      end else begin
        if (pop[i]) begin
          qh[i] = (qh[i] + 1) % 4;
          qn[i] = qn[i] - 1;
        end
        if (acc[i]) begin
          slot         = (qh[i] + qn[i]) % 4;
          qd[i][slot]  = ed;
          qe[i][slot]  = ee;
          qv[i][slot]  = cyc + lat(i) - 1;
          qn[i]        = qn[i] + 1;
        end
      end
    end
    if (load_en) mm[load_addr] = load_data;
    #2;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h00000013; prog[1] = 32'h088000ef;
    prog[2] = 32'hffdff06f; prog[3] = 32'h00008067;
    for (int i = 0; i < 2; i++) begin qh[i] = 0; qn[i] = 0; end
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

    phase = "reset";
    #1;
    chk_reset();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    // Fill the whole array; a pending request must stay blocked throughout.
    phase = "preload";
    req_valid = 1'b1; req_addr = 32'h0;
    load_en = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      load_addr = 6'(w);
      load_data = (w < 4) ? prog[w] : $urandom;
      tick();
    end
    load_en = 1'b0;
    req_valid = 1'b0;

    phase = "b2b";
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_addr = 32'(4 * k);
      tick();
    end
    idle(4);

    phase = "backpressure";
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_addr = 32'(16 + 4 * k);
      tick();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    idle(4);

    phase = "range";
    req_valid = 1'b1; req_addr = 32'h100; tick();
    req_addr = 32'h0; tick();
    req_addr = 32'h8000_0004; tick();
    req_addr = 32'hFC; tick();
    idle(4);

    phase = "flush";
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8; tick();
    req_addr = 32'hC; tick();
    req_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; rsp_ready = 1'b1;
    idle(4);

    phase = "load";
    req_valid = 1'b1; req_addr = 32'h14;
    load_en = 1'b1; load_addr = 6'd5; load_data = 32'hdeadbeef; tick();
    tick();
    load_en = 1'b0; tick();
    idle(4);

    phase = "misalign";
    req_valid = 1'b1; req_addr = 32'h6; tick();
    idle(4);

    phase = "midreset";
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset();
    for (int i = 0; i < 2; i++) begin qh[i] = 0; qn[i] = 0; end
    @(posedge clk); #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h14; tick();
    idle(4);

    phase = "random";
    for (int k = 0; k < 500; k++) begin
      req_valid = ($urandom % 4) != 0;
      case ($urandom % 10)
        0:       req_addr = $urandom;
        1:       req_addr = 32'h100 + 32'($urandom_range(0, 63));
        default: req_addr = 32'($urandom_range(0, 255));
      endcase
      rsp_ready = ($urandom % 10) < 7;
      flush     = ($urandom % 20) == 0;
      load_en   = ($urandom % 20) == 0;
      load_addr = 6'($urandom_range(0, 63));
      load_data = $urandom;
      tick();
    end
    flush = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
